// File: rtl/and4_sweep_checker_if.sv
// ============================================================================
// Module      : and4_sweep_checker_if
// Description : Stimulus/verdict bundle between the AND4 sweep checker and
//               its environment (gate under check plus controller).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface and4_sweep_checker_if #(
    parameter int ERR_W = 5
);
    logic             start;
    logic             out_in;
    logic             m;
    logic             n;
    logic             p;
    logic             q;
    logic [3:0]       code;
    logic             busy;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;
    logic             done;
    logic             pass;

    // Environment side: issues start, returns the gate output, observes the rest.
    modport master (
        output start, out_in,
        input  m, n, p, q, code, busy, mismatch, err_cnt, done, pass
    );

    // Checker side.
    modport slave (
        input  start, out_in,
        output m, n, p, q, code, busy, mismatch, err_cnt, done, pass
    );
endinterface

`default_nettype wire

// File: rtl/and4_sweep_checker.sv
// ============================================================================
// Module      : and4_sweep_checker
// Description : Sweeps codes 0..15 onto a 4-input AND gate, samples its output
//               after a settle window and reports mismatch count / verdict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and4_sweep_checker #(
    parameter int HOLD_CYCLES   = 19,
    parameter int SETTLE_CYCLES = 15,
    parameter int ERR_W         = 5
) (
    input  wire                   clk,
    input  wire                   rst_n,
    and4_sweep_checker_if.slave   bus
);

    generate
        if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255 ||
            SETTLE_CYCLES < 1 || SETTLE_CYCLES >= HOLD_CYCLES) begin : g_param_check
            $error("and4_sweep_checker: illegal HOLD_CYCLES/SETTLE_CYCLES");
        end
    endgenerate

    localparam logic [7:0]       c_settle   = 8'(SETTLE_CYCLES);
    localparam logic [7:0]       c_hold_end = 8'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [3:0]       r_code;
    logic             r_busy;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_done;
    logic             r_pass;

    logic             w_miss;
    logic [ERR_W-1:0] w_err_next;

    // Gate output is combinational from the registered code, so it is compared raw.
    always_comb begin
        w_miss     = 1'b0;
        w_err_next = r_err_cnt;
        if (r_state == S_RUN && r_cnt == c_settle) begin
            w_miss = (bus.out_in != (&r_code));
        end
        if (w_miss && r_err_cnt != c_err_max) begin
            w_err_next = r_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_code     <= 4'd0;
            r_busy     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_code    <= 4'd0;
                        r_cnt     <= 8'd0;
                        r_err_cnt <= '0;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt      <= r_cnt + 8'd1;
                    r_mismatch <= w_miss;
                    r_err_cnt  <= w_err_next;
                    // A sample coinciding with the advance still uses the old code.
                    if (r_cnt == c_hold_end) begin
                        r_cnt <= 8'd0;
                        if (r_code != 4'd15) begin
                            r_code <= r_code + 4'd1;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_code  <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.code     = r_code;
    assign bus.m        = r_code[3];
    assign bus.n        = r_code[2];
    assign bus.p        = r_code[1];
    assign bus.q        = r_code[0];
    assign bus.busy     = r_busy;
    assign bus.mismatch = r_mismatch;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_and4_sweep_checker.sv
// ============================================================================
// Module      : tb_and4_sweep_checker
// Description : Self-checking bench for and4_sweep_checker with behavioural
//               gate models (ideal, delayed, stuck-at-1, single-code fault).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and4_sweep_checker;

    localparam int HOLD   = 19;
    localparam int SETTLE = 15;
    localparam int DELAY  = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    and4_sweep_checker_if #(.ERR_W(5)) bus ();
    and4_sweep_checker_if #(.ERR_W(3)) bus3 ();

    and4_sweep_checker #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .ERR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    and4_sweep_checker #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .ERR_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    // Gate models: 0 ideal, 1 delayed by DELAY clocks, 2 stuck at 1, 3 fault on code inj.
    int          mode = 0;
    int          inj  = 0;
    logic [DELAY-1:0] dly = '0;
    logic        ideal;
    assign ideal = bus.m & bus.n & bus.p & bus.q;
    always @(posedge clk) dly <= {dly[DELAY-2:0], ideal};

    always_comb begin
        case (mode)
            1:       bus.out_in = dly[DELAY-1];
            2:       bus.out_in = 1'b1;
            3:       bus.out_in = ideal ^ (int'(bus.code) == inj);
            default: bus.out_in = ideal;
        endcase
    end
    assign bus3.out_in = 1'b1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gate output seen at the sample point of code c, from elapsed time since the start edge.
    function automatic bit gate_at_sample(input int md, input int c, input int ij);
        int t;
        t = c * HOLD + SETTLE;
        case (md)
            1:       return (t >= DELAY) ? (((t - DELAY) / HOLD) == 15) : 1'b0;
            2:       return 1'b1;
            3:       return (c == 15) ^ (c == ij);
            default: return (c == 15);
        endcase
    endfunction

    function automatic int model_errs(input int md, input int ij, input int w);
        int e = 0;
        for (int c = 0; c < 16; c++)
            if (gate_at_sample(md, c, ij) != (c == 15)) e++;
        return (e > (1 << w) - 1) ? (1 << w) - 1 : e;
    endfunction

    task automatic sweep(input bit hold, input bit also3,
                         output int cyc, output int pulses, output int pcode);
        cyc = 0; pulses = 0; pcode = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus3.start = also3;
        @(posedge clk); #1;
        if (!hold) begin
            bus.start = 1'b0;
            bus3.start = 1'b0;
        end
        check("start_busy", 32'(bus.busy), 1);
        check("start_code", 32'(bus.code), 0);
        while (!bus.done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mismatch) begin
                pulses++;
                pcode = int'(bus.code);
            end
        end
        bus.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    task automatic idle_gap();
        repeat (DELAY + 10 + $urandom_range(0, 20)) @(posedge clk);
    endtask

    task automatic verdict(input string tag, input int exp_err, input int exp_pulses,
                           input int cyc, input int pulses);
        check({tag, "_latency"}, cyc, 16 * HOLD);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), exp_err);
        check({tag, "_pass"}, 32'(bus.pass), (exp_err == 0) ? 1 : 0);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_code"}, 32'(bus.code), 0);
    endtask

    initial begin
        int cyc, pulses, pcode, e, guard;
        bus.start = 1'b0;
        bus3.start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", 32'(bus.code), 0);
        check("rst_mnpq", {28'd0, bus.m, bus.n, bus.p, bus.q}, 0);
        check("rst_flags", {28'd0, bus.busy, bus.mismatch, bus.done, bus.pass}, 0);
        check("rst_err", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);

        // 1: ideal gate
        mode = 0;
        sweep(1'b0, 1'b0, cyc, pulses, pcode);
        e = model_errs(0, 0, 5);
        verdict("ideal", e, e, cyc, pulses);

        // 2: delayed gate, only code 15 fails
        idle_gap();
        mode = 1;
        sweep(1'b0, 1'b0, cyc, pulses, pcode);
        e = model_errs(1, 0, 5);
        verdict("delay", e, e, cyc, pulses);
        check("delay_pulse_code", pcode, 15);

        // 3 and 4: stuck at 1 on both widths
        idle_gap();
        mode = 2;
        sweep(1'b0, 1'b1, cyc, pulses, pcode);
        e = model_errs(2, 0, 5);
        verdict("stuck", e, e, cyc, pulses);
        check("sat_err_cnt", 32'(bus3.err_cnt), model_errs(2, 0, 3));
        check("sat_done", 32'(bus3.done), 1);
        check("sat_pass", 32'(bus3.pass), 0);

        // 5: asynchronous reset at code 7, then a clean sweep
        idle_gap();
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (bus.code != 4'd7 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_code7", 32'(bus.code), 7);
        #1 rst_n = 1'b0;
        #1;
        check("arst_code", 32'(bus.code), 0);
        check("arst_mnpq", {28'd0, bus.m, bus.n, bus.p, bus.q}, 0);
        check("arst_flags", {28'd0, bus.busy, bus.mismatch, bus.done, bus.pass}, 0);
        check("arst_err", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_idle_busy", 32'(bus.busy), 0);
        sweep(1'b0, 1'b0, cyc, pulses, pcode);
        verdict("post_rst", 0, 0, cyc, pulses);

        // 6: start held throughout, one randomly chosen faulty code
        idle_gap();
        mode = 3;
        inj = int'($urandom_range(0, 15));
        sweep(1'b1, 1'b0, cyc, pulses, pcode);
        e = model_errs(3, inj, 5);
        verdict("held", e, e, cyc, pulses);
        check("held_pulse_code", pcode, inj);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check("held_done_stable", 32'(bus.done), 1);
        check("held_err_stable", 32'(bus.err_cnt), e);
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("restart_err", 32'(bus.err_cnt), 0);
        check("restart_code", 32'(bus.code), 0);
        check("restart_busy", 32'(bus.busy), 1);
        check("restart_done", 32'(bus.done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/and4_sweep_checker.md
Name: and4_sweep_checker

Overview:
- Synthesizable stimulus-and-check engine for the 4-input, two-level AND gate block, which computes out = (m & n) & (p & q).
- Drives the gate's m, n, p, q inputs through all 16 codes, 0 to 15.
- Holds each code for a fixed number of clocks and samples the gate's returned output after a settle window.
- Compares the sample against the expected AND, then reports a mismatch count and a pass/fail verdict.

Parameters:
- HOLD_CYCLES, 19, clocks each code is held on m/n/p/q; legal range 2..255.
- SETTLE_CYCLES, 15, clock index within the hold window at which out_in is sampled; must satisfy 1 <= SETTLE_CYCLES < HOLD_CYCLES, otherwise elaboration error.
- ERR_W, 5, width of the mismatch counter.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- out_in  input  1  output returned from the gate under check.
- m  output  1  stimulus bit 3 (code[3]).
- n  output  1  stimulus bit 2 (code[2]).
- p  output  1  stimulus bit 1 (code[1]).
- q  output  1  stimulus bit 0 (code[0]).
- code  output  4  current stimulus code.
- busy  output  1  high while sweeping.
- mismatch  output  1  one-cycle pulse per failed comparison.
- err_cnt  output  ERR_W  saturating mismatch count.
- done  output  1  sweep complete; level.
- pass  output  1  done and err_cnt == 0; level.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - code, m, n, p, q, busy, mismatch, done and pass all go to 0; err_cnt goes to 0.
  - Hold counter cnt (8-bit) goes to 0.
  - Reset asserted mid-sweep aborts immediately with no partial verdict.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: go to RUN, busy = 1, code = 0, cnt = 0, err_cnt = 0.
  - Outputs m/n/p/q always equal code bits, registered.
- RUN:
  - cnt increments by 1 every clock.
  - Sample edge (cnt == SETTLE_CYCLES):
    - expected = &code, i.e. 1 only for code 15.
    - If out_in != expected: mismatch = 1 for the next cycle only, and err_cnt += 1, saturating at 2^ERR_W - 1.
    - out_in is compared raw; the gate path is combinational from registered m/n/p/q, so no synchronizer is used.
  - End-of-window edge (cnt == HOLD_CYCLES - 1):
    - If code < 15: code += 1, cnt = 0.
    - If code == 15: go to DONE, busy = 0, done = 1, pass = (err_cnt_next == 0), and code/m/n/p/q return to 0.
  - start is ignored in RUN.
- Sweep timing: from the start edge to done rising is exactly 16*HOLD_CYCLES clocks, which is 304 at default.
- DONE:
  - done, pass and err_cnt are held stable.
  - An edge with start = 1 clears done, pass and err_cnt, and enters RUN with code = 0, as from IDLE.
- Simultaneous events:
  - If a mismatch occurs on the final sample edge of code 15, it is counted in err_cnt before pass is computed.
  - When SETTLE_CYCLES == HOLD_CYCLES - 1, the sample and the code advance occur on the same edge; the comparison uses the old code.
- mismatch is never asserted outside RUN, except for its trailing cycle after the final sample.

Test Plan:
1. Zero-delay ideal gate model, start pulsed once:
   - done rises 304 clocks after the start edge.
   - err_cnt = 0, pass = 1, no mismatch pulses.
2. Gate model with 30-clock output delay (exceeds SETTLE_CYCLES = 15):
   - Code 15 samples a stale 0, so exactly one mismatch pulse, during code 15.
   - err_cnt = 1, pass = 0.
3. out_in stuck at 1:
   - Codes 0..14 fail, giving 15 mismatch pulses.
   - err_cnt = 15, pass = 0.
4. ERR_W = 3 with out_in stuck at 1:
   - err_cnt saturates at 7 and does not wrap.
   - pass = 0.
5. rst_n pulsed low while code = 7:
   - All outputs read 0 asynchronously, before the next edge; state is IDLE.
   - A later start produces a full 304-clock sweep from code 0.
6. start held high throughout RUN, with an error injected on one code:
   - No restart occurs mid-sweep; done rises with err_cnt = 1.
   - A subsequent start in DONE clears err_cnt to 0 and begins a new sweep at code 0.
